// File: rtl/step_pattern_pkg.sv
// Shared definitions for the step pattern generator: mode encodings and
// state-count helpers used by the sequencer and the pattern decoder.
package step_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_WALK0 = 2'd3
  } mode_e;

  // Counting modes cover every code of the index; walking modes use one state per bit.
  function automatic int unsigned state_count(input mode_e mode, input int unsigned width);
    if (mode == MODE_BIN || mode == MODE_GRAY) begin
      return 32'd1 << width;
    end
    return width;
  endfunction

  function automatic int unsigned last_state(input mode_e mode, input int unsigned width);
    return state_count(mode, width) - 32'd1;
  endfunction

endpackage

// File: rtl/step_pattern_gen_if.sv
// Control and status bundle of the step pattern generator; master drives the
// controls, slave is the generator itself.
interface step_pattern_gen_if #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STEP_W = 8
);

  logic              en;
  logic              clear;
  logic [STEP_W-1:0] step_len;
  logic [1:0]        mode;
  logic              dir;
  logic              one_shot;
  logic [WIDTH-1:0]  index;
  logic [WIDTH-1:0]  pattern;
  logic              tick;
  logic              wrap;
  logic              done;

  modport master (
    output en, clear, step_len, mode, dir, one_shot,
    input  index, pattern, tick, wrap, done
  );

  modport slave (
    input  en, clear, step_len, mode, dir, one_shot,
    output index, pattern, tick, wrap, done
  );

endinterface

// File: rtl/step_pattern_gen_pattern_decode.sv
// Combinational decode of a state index into the output pattern for the
// selected sequence mode.
module pattern_decode
  import step_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] index,
  input  mode_e            mode,
  output logic [WIDTH-1:0] pattern
);

  logic [WIDTH-1:0] one_hot_c;

  always_comb begin
    one_hot_c = WIDTH'(1) << index;
    pattern   = index;
    case (mode)
      MODE_BIN:   pattern = index;
      MODE_GRAY:  pattern = index ^ (index >> 1);
      MODE_WALK1: pattern = one_hot_c;
      MODE_WALK0: pattern = ~one_hot_c;
      default:    pattern = index;
    endcase
  end

endmodule

// File: rtl/step_pattern_gen.sv
// Programmable stepping sequencer: dwells L cycles per state, walks the index
// up or down through the selected sequence, wrapping or stopping at the end.
module step_pattern_gen
  import step_pattern_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STEP_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  step_pattern_gen_if.slave bus
);

  logic [STEP_W-1:0] cnt_q;
  logic [WIDTH-1:0]  index_q;
  logic              tick_q;
  logic              wrap_q;
  logic              done_q;
  mode_e             mode_q;
  logic              dir_q;
  logic              os_q;

  logic [WIDTH-1:0]  last_c;
  logic [WIDTH-1:0]  start_c;
  logic [WIDTH-1:0]  term_c;
  logic [WIDTH-1:0]  clr_last_c;
  logic [WIDTH-1:0]  clr_start_c;
  logic [STEP_W-1:0] dwell_m1_c;
  logic              count_c;
  logic              advance_c;
  logic [WIDTH-1:0]  pattern_c;

  // Sequence end points for the captured configuration and for the one being loaded by clear.
  always_comb begin
    last_c      = WIDTH'(last_state(mode_q, WIDTH));
    start_c     = dir_q ? last_c : '0;
    term_c      = dir_q ? '0 : last_c;
    clr_last_c  = WIDTH'(last_state(mode_e'(bus.mode), WIDTH));
    clr_start_c = bus.dir ? clr_last_c : '0;
  end

  // step_len is used live; zero behaves as a one-cycle dwell.
  always_comb begin
    dwell_m1_c = (bus.step_len == '0) ? '0 : bus.step_len - STEP_W'(1);
    count_c    = bus.en && !done_q;
    advance_c  = count_c && (cnt_q >= dwell_m1_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      index_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_BIN;
      dir_q   <= 1'b0;
      os_q    <= 1'b0;
    end else if (bus.clear) begin
      cnt_q   <= '0;
      index_q <= clr_start_c;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= mode_e'(bus.mode);
      dir_q   <= bus.dir;
      os_q    <= bus.one_shot;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (advance_c) begin
        cnt_q <= '0;
        if (index_q == term_c) begin
          // A finished one-shot freezes on the terminal state without a tick.
          if (os_q) begin
            done_q <= 1'b1;
          end else begin
            index_q <= start_c;
            tick_q  <= 1'b1;
            wrap_q  <= 1'b1;
          end
        end else begin
          index_q <= dir_q ? index_q - WIDTH'(1) : index_q + WIDTH'(1);
          tick_q  <= 1'b1;
        end
      end else if (count_c) begin
        cnt_q <= cnt_q + STEP_W'(1);
      end
    end
  end

  pattern_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .index   (index_q),
    .mode    (mode_q),
    .pattern (pattern_c)
  );

  assign bus.index   = index_q;
  assign bus.pattern = pattern_c;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_step_pattern_gen.sv
// Self-checking bench for step_pattern_gen: drives WIDTH=2 and WIDTH=4 copies
// with shared stimulus and checks both against a cycle model via scoreboards.
module tb_step_pattern_gen;

  localparam int unsigned STEP_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [7:0] step_len;
  logic [1:0] mode;
  logic       dir;
  logic       os;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  step_pattern_gen_if #(.WIDTH(2), .STEP_W(STEP_W)) bus2 ();
  step_pattern_gen_if #(.WIDTH(4), .STEP_W(STEP_W)) bus4 ();

  assign bus2.en = en;       assign bus4.en = en;
  assign bus2.clear = clear; assign bus4.clear = clear;
  assign bus2.step_len = step_len; assign bus4.step_len = step_len;
  assign bus2.mode = mode;   assign bus4.mode = mode;
  assign bus2.dir = dir;     assign bus4.dir = dir;
  assign bus2.one_shot = os; assign bus4.one_shot = os;

  step_pattern_gen #(.WIDTH(2), .STEP_W(STEP_W)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  step_pattern_gen #(.WIDTH(4), .STEP_W(STEP_W)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state, index 0 -> WIDTH=2 copy, index 1 -> WIDTH=4 copy.
  typedef struct {
    int idx;
    int pat;
    bit tick;
    bit wrap;
    bit done;
  } exp_t;

  exp_t sb2[$];
  exp_t sb4[$];
  int   m_idx[2];
  int   m_cnt[2];
  bit   m_tick[2];
  bit   m_wrap[2];
  bit   m_done[2];
  int   m_mode;
  bit   m_dir;
  bit   m_os;

  function automatic int wd(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int nstates(input int md, input int w);
    return (md < 2) ? (1 << w) : w;
  endfunction

  function automatic int ref_pattern(input int idx, input int md, input int w);
    int mask;
    mask = (1 << w) - 1;
    case (md)
      0:       return idx;
      1:       return idx ^ (idx >> 1);
      2:       return 1 << idx;
      default: return mask & ~(1 << idx);
    endcase
  endfunction

  task automatic model_edge();
    int last;
    int len;
    exp_t e;
    if (!rst_n) begin
      m_mode = 0; m_dir = 0; m_os = 0;
    end else if (clear) begin
      m_mode = int'(mode); m_dir = dir; m_os = os;
    end
    for (int k = 0; k < 2; k++) begin
      last = nstates(m_mode, wd(k)) - 1;
      if (!rst_n) begin
        m_idx[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
      end else if (clear) begin
        m_idx[k] = m_dir ? last : 0;
        m_cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
      end else begin
        m_tick[k] = 0;
        m_wrap[k] = 0;
        if (en && !m_done[k]) begin
          len = (step_len == 0) ? 1 : int'(step_len);
          if (m_cnt[k] + 1 < len) begin
            m_cnt[k]++;
          end else begin
            m_cnt[k] = 0;
            if (m_idx[k] == (m_dir ? 0 : last)) begin
              if (m_os) m_done[k] = 1;
              else begin
                m_idx[k] = m_dir ? last : 0;
                m_tick[k] = 1;
                m_wrap[k] = 1;
              end
            end else begin
              m_idx[k] = m_dir ? m_idx[k] - 1 : m_idx[k] + 1;
              m_tick[k] = 1;
            end
          end
        end
      end
      e.idx  = m_idx[k];
      e.pat  = ref_pattern(m_idx[k], m_mode, wd(k));
      e.tick = m_tick[k];
      e.wrap = m_wrap[k];
      e.done = m_done[k];
      if (k == 0) sb2.push_back(e);
      else        sb4.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_edge();
  end

  // Event log used by the directed timing and sequence checks.
  int ref_cyc;
  int first_tick = -1;
  int wrap_cyc   = -1;
  int done_cyc   = -1;
  int log2[$];
  int log4[$];

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb2.size() == 0 || sb4.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb2.pop_front();
      check("idx2", 32'(bus2.index), e.idx);
      check("pat2", 32'(bus2.pattern), e.pat);
      check("tick2", 32'(bus2.tick), 32'(e.tick));
      check("wrap2", 32'(bus2.wrap), 32'(e.wrap));
      check("done2", 32'(bus2.done), 32'(e.done));
      e = sb4.pop_front();
      check("idx4", 32'(bus4.index), e.idx);
      check("pat4", 32'(bus4.pattern), e.pat);
      check("tick4", 32'(bus4.tick), 32'(e.tick));
      check("wrap4", 32'(bus4.wrap), 32'(e.wrap));
      check("done4", 32'(bus4.done), 32'(e.done));
    end
    if (bus2.tick === 1'b1) log2.push_back(int'(bus2.pattern));
    if (bus4.tick === 1'b1) log4.push_back(int'(bus4.pattern));
    if (bus2.tick === 1'b1 && first_tick < 0) first_tick = cyc;
    if (bus2.wrap === 1'b1 && wrap_cyc < 0)   wrap_cyc = cyc;
    if (bus2.done === 1'b1 && done_cyc < 0)   done_cyc = cyc;
  end

  task automatic mark();
    ref_cyc    = cyc;
    first_tick = -1;
    wrap_cyc   = -1;
    done_cyc   = -1;
    log2.delete();
    log4.delete();
  endtask

  task automatic do_clear(input int md, input bit d, input bit o, input int sl);
    mode     = 2'(md);
    dir      = d;
    os       = o;
    step_len = 8'(sl);
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mark();
  endtask

  task automatic check_seq(input string tag, input int which,
                           input int e0, input int e1, input int e2, input int e3);
    int exp_v[4];
    int got;
    exp_v = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      if (which == 2) got = (log2.size() > i) ? log2[i] : -1;
      else            got = (log4.size() > i) ? log4[i] : -1;
      check(tag, got, exp_v[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; step_len = 8'd5;
    mode = 2'd0; dir = 1'b0; os = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pat2", 32'(bus2.pattern), 0);
    check("rst_idx4", 32'(bus4.index), 0);
    rst_n = 1'b1;

    // Binary up, dwell 5, wrapping.
    en = 1'b1;
    do_clear(0, 0, 0, 5);
    repeat (22) @(negedge clk);
    check("adv_lat", first_tick - ref_cyc, 5);
    check("wrap_lat", wrap_cyc - ref_cyc, 20);
    check_seq("bin2_seq", 2, 1, 2, 3, 0);
    check_seq("bin4_seq", 4, 1, 2, 3, 4);

    // Gray up.
    do_clear(1, 0, 0, 2);
    repeat (9) @(negedge clk);
    check_seq("gray2_seq", 2, 1, 3, 2, 0);
    check("gray_wrap", wrap_cyc - ref_cyc, 8);

    // Walking one down and walking zero up on the 4-bit copy.
    do_clear(2, 1, 0, 3);
    check("walk1_start", 32'(bus4.pattern), 8);
    repeat (13) @(negedge clk);
    check_seq("walk1_seq", 4, 4, 2, 1, 8);
    do_clear(3, 0, 0, 3);
    check("walk0_start", 32'(bus4.pattern), 14);
    repeat (13) @(negedge clk);
    check_seq("walk0_seq", 4, 13, 11, 7, 14);

    // One-shot down, then restart.
    do_clear(0, 1, 1, 2);
    check("os_start", 32'(bus2.index), 3);
    repeat (12) @(negedge clk);
    check("done_lat", done_cyc - ref_cyc, 8);
    check_seq("os_seq", 2, 2, 1, 0, -1);
    check("os_hold", 32'(bus2.index), 0);
    do_clear(0, 1, 1, 2);
    check("os_restart", 32'(bus2.index), 3);
    check("os_done_clr", 32'(bus2.done), 0);

    // Dwell of 0 and 1 both advance every cycle.
    do_clear(0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("ticks_l0", log2.size(), 8);
    do_clear(0, 0, 0, 1);
    repeat (8) @(negedge clk);
    check("ticks_l1", log2.size(), 8);

    // Enable gap mid-dwell stretches the state by the gap length.
    do_clear(0, 0, 0, 4);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    check("en_hold", first_tick - ref_cyc, 8);

    // Shortening the dwell mid-state advances on the next enabled edge.
    do_clear(0, 0, 0, 6);
    repeat (4) @(negedge clk);
    step_len = 8'd2;
    @(negedge clk);
    check("len_drop", first_tick - ref_cyc, 5);

    // Reset mid-sequence discards progress.
    do_clear(1, 1, 0, 3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_idx", 32'(bus4.index), 0);
    check("mid_rst_pat", 32'(bus2.pattern), 0);
    check("mid_rst_done", 32'(bus2.done), 0);
    rst_n = 1'b1;
    step_len = 8'd3;
    mark();
    repeat (5) @(negedge clk);
    check("post_rst_tick", first_tick - ref_cyc, 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 19) == 0);
      step_len = 8'($urandom_range(0, 4));
      mode     = 2'($urandom_range(0, 3));
      dir      = 1'($urandom_range(0, 1));
      os       = 1'($urandom_range(0, 1));
      rst_n    = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
